// File: rtl/fmul_share_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared fmul arbiter.
// Optional exception port exc_sticky exists only when FMUL_ARB_EXC_EN is defined.
interface fmul_share_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_x1;
  logic [NREQ*32-1:0] req_x2;
  logic [NREQ-1:0]    resp_valid;
  logic [NREQ-1:0]    resp_ready;
  logic [31:0]        resp_y;
  logic               resp_ovf;
  logic               resp_udf;
  logic               busy;
`ifdef FMUL_ARB_EXC_EN
  logic [1:0]         exc_sticky;

  modport master (
    output req_valid, req_x1, req_x2, resp_ready,
    input  req_ready, resp_valid, resp_y, resp_ovf, resp_udf, busy, exc_sticky
  );
  modport slave (
    input  req_valid, req_x1, req_x2, resp_ready,
    output req_ready, resp_valid, resp_y, resp_ovf, resp_udf, busy, exc_sticky
  );
`else
  modport master (
    output req_valid, req_x1, req_x2, resp_ready,
    input  req_ready, resp_valid, resp_y, resp_ovf, resp_udf, busy
  );
  modport slave (
    input  req_valid, req_x1, req_x2, resp_ready,
    output req_ready, resp_valid, resp_y, resp_ovf, resp_udf, busy
  );
`endif
endinterface

// File: rtl/fmul_share_arbiter.sv
// Shared single-precision multiplier with round-robin arbitration between NREQ requesters.
// One operation in flight; operands and result are registered around a combinational fmul.
// Optional feature macro: FMUL_ARB_EXC_EN (registered ovf/udf flags plus sticky exc_sticky).
//
// state  | meaning
// S_IDLE | nothing in flight, grant window open
// S_CALC | fmul evaluating operand registers, result captured at next edge
// S_RESP | result presented to owner; grant window opens when owner takes it

// Combinational IEEE single multiply, round-to-nearest-even, subnormals flushed to zero.
module fmul (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf,
  output logic        udf
);
  logic        sgn;
  logic [7:0]  e1, e2;
  logic        z1, z2, i1, i2, n1, n2;
  logic [47:0] prod;
  logic [22:0] mant;
  logic        guard, sticky, rnd_up;
  logic [23:0] mant_r;
  logic [9:0]  exp_a, exp_f;

  // Multiply significands, normalise by one bit, round, then classify the result.
  always_comb begin
    sgn    = x1[31] ^ x2[31];
    e1     = x1[30:23];
    e2     = x2[30:23];
    z1     = (e1 == 8'h00);
    z2     = (e2 == 8'h00);
    i1     = (e1 == 8'hFF);
    i2     = (e2 == 8'hFF);
    n1     = i1 && (x1[22:0] != 23'd0);
    n2     = i2 && (x2[22:0] != 23'd0);
    prod   = {24'd0, 1'b1, x1[22:0]} * {24'd0, 1'b1, x2[22:0]};
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    rnd_up = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {23'd0, rnd_up};
    // exponent kept biased twice (+254) so it never goes negative
    exp_a  = {2'b00, e1} + {2'b00, e2} + {9'd0, prod[47]};
    exp_f  = exp_a + {9'd0, mant_r[23]};
    y      = {sgn, 31'd0};
    ovf    = 1'b0;
    udf    = 1'b0;
    if (n1 || n2 || (i1 && z2) || (i2 && z1)) begin
      y = 32'h7FC0_0000;
    end else if (i1 || i2) begin
      y = {sgn, 8'hFF, 23'd0};
    end else if (z1 || z2) begin
      y = {sgn, 31'd0};
    end else if (exp_f >= 10'd382) begin
      ovf = 1'b1;
      y   = {sgn, 8'hFF, 23'd0};
    end else if (exp_f <= 10'd127) begin
      udf = 1'b1;
      y   = {sgn, 31'd0};
    end else begin
      y = {sgn, exp_f[7:0] - 8'd127, mant_r[22:0]};
    end
  end
endmodule

module fmul_share_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  fmul_share_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [31:0]     x1_q, x1_d;
  logic [31:0]     x2_q, x2_d;
  logic [31:0]     y_q, y_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic            busy_q, busy_d;

  logic [31:0]     fm_y;
  logic            fm_ovf, fm_udf;
  logic            retire, grant_win, gnt_any, accept;
  logic [IDW-1:0]  gnt_idx, cidx;

  fmul u_fmul (
    .x1  (x1_q),
    .x2  (x2_q),
    .y   (fm_y),
    .ovf (fm_ovf),
    .udf (fm_udf)
  );

  assign retire    = (state_q == S_RESP) && bus.resp_ready[owner_q];
  assign grant_win = (state_q == S_IDLE) || retire;
  assign accept    = grant_win && gnt_any;

  // Round-robin search: first valid requester after the last granted one.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cidx    = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cidx = (cidx == IDW'(NREQ - 1)) ? '0 : cidx + IDW'(1);
      if (!gnt_any && bus.req_valid[cidx]) begin
        gnt_any = 1'b1;
        gnt_idx = cidx;
      end
    end
  end

`ifdef FMUL_ARB_EXC_EN
  logic       ovf_q, ovf_d;
  logic       udf_q, udf_d;
  logic [1:0] exc_sticky_q, exc_sticky_d;
`else
  // ovf/udf have no consumer in this build
  logic       unused_exc;
  assign unused_exc = fm_ovf | fm_udf;
`endif

  // Next-state logic: FSM sequencing, operand capture on accept, result capture in CALC.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    x1_d         = x1_q;
    x2_d         = x2_q;
    y_d          = y_q;
    resp_valid_d = resp_valid_q;
`ifdef FMUL_ARB_EXC_EN
    ovf_d        = ovf_q;
    udf_d        = udf_q;
    exc_sticky_d = exc_sticky_q;
`endif
    case (state_q)
      S_IDLE: ;
      S_CALC: begin
        y_d          = fm_y;
`ifdef FMUL_ARB_EXC_EN
        ovf_d        = fm_ovf;
        udf_d        = fm_udf;
`endif
        resp_valid_d = NREQ'(1) << owner_q;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (retire) begin
          resp_valid_d = '0;
          state_d      = S_IDLE;
`ifdef FMUL_ARB_EXC_EN
          exc_sticky_d = exc_sticky_q | {ovf_q, udf_q};
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    // an accept in RESP overrides the return to IDLE: back-to-back issue
    if (accept) begin
      x1_d     = bus.req_x1[32*gnt_idx +: 32];
      x2_d     = bus.req_x2[32*gnt_idx +: 32];
      owner_d  = gnt_idx;
      rr_ptr_d = gnt_idx;
      state_d  = S_CALC;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= IDW'(NREQ - 1);
      owner_q      <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      y_q          <= '0;
      resp_valid_q <= '0;
      busy_q       <= 1'b0;
`ifdef FMUL_ARB_EXC_EN
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      exc_sticky_q <= 2'b00;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      y_q          <= y_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
`ifdef FMUL_ARB_EXC_EN
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      exc_sticky_q <= exc_sticky_d;
`endif
    end
  end

  assign bus.req_ready  = accept ? (NREQ'(1) << gnt_idx) : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_y     = y_q;
  assign bus.busy       = busy_q;
`ifdef FMUL_ARB_EXC_EN
  assign bus.resp_ovf   = ovf_q;
  assign bus.resp_udf   = udf_q;
  assign bus.exc_sticky = exc_sticky_q;
`else
  assign bus.resp_ovf   = 1'b0;
  assign bus.resp_udf   = 1'b0;
`endif
endmodule
